// File: rtl/vdp_port_if.sv
`default_nettype none
// ============================================================================
// Module      : vdp_port_if
// Description : CPU-side I/O port bundle of the VDP (ports 0x98/0x99).
// Revision    : 1.0 - initial release
// ============================================================================
interface vdp_port_if;
    logic       cpu_a0;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       busy;

    modport master (
        output cpu_a0, cpu_wr, cpu_rd, cpu_din,
        input  cpu_dout, busy
    );

    modport slave (
        input  cpu_a0, cpu_wr, cpu_rd, cpu_din,
        output cpu_dout, busy
    );
endinterface
`default_nettype wire

// File: rtl/vdp_port.sv
`default_nettype none
// ============================================================================
// Module      : vdp_port
// Description : TMS9918-style CPU port: register file, VRAM access with
//               read-ahead, and frame status flag / interrupt generation.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_port #(
    parameter int ADDR_W = 14
) (
    input  wire logic              clk,
    input  wire logic              n_reset,
    vdp_port_if.slave              cpu,
    output logic [ADDR_W-1:0]      vram_addr,
    output logic [7:0]             vram_wdata,
    output logic                   vram_we,
    output logic                   vram_re,
    input  wire logic [7:0]        vram_rdata,
    input  wire logic              frame_int,
    output logic [1:0]             mode,
    output logic [13:0]            name_table_addr,
    output logic [13:0]            font_addr,
    output logic                   video_on,
    output logic [3:0]             text_color,
    output logic [3:0]             back_color,
    output logic                   n_int
);

    localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREF = 2'd1,
        S_WAIT = 2'd2
    } ra_state_t;

    ra_state_t         r_state;
    logic [7:0]        r_reg [8];
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_rbuf;
    logic [7:0]        r_lbyte;
    logic              r_lf;
    logic              r_f;
    logic [1:0]        r_sync;
    logic              r_int_prev;
    logic [7:0]        r_cpu_dout;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [7:0]        r_vram_wdata;
    logic              r_vram_we;
    logic              r_vram_re;

    logic              w_busy;
    logic              w_wr;
    logic              w_rd;
    logic              w_ctrl_wr;
    logic              w_data_wr;
    logic              w_data_rd;
    logic              w_stat_rd;
    logic              w_setup;
    logic              w_ra_start;
    logic [ADDR_W-1:0] w_new_addr;
    logic [ADDR_W-1:0] w_ra_addr;
    logic              w_edge;
    logic [1:0]        w_mode;
    logic              w_unused;

    // Strobes are ignored entirely while a read-ahead owns the VRAM port.
    assign w_busy     = (r_state != S_IDLE);
    assign w_wr       = cpu.cpu_wr & ~w_busy;
    assign w_rd       = cpu.cpu_rd & ~cpu.cpu_wr & ~w_busy;
    assign w_ctrl_wr  = w_wr &  cpu.cpu_a0;
    assign w_data_wr  = w_wr & ~cpu.cpu_a0;
    assign w_data_rd  = w_rd & ~cpu.cpu_a0;
    assign w_stat_rd  = w_rd &  cpu.cpu_a0;
    assign w_setup    = w_ctrl_wr & r_lf & ~cpu.cpu_din[7];
    assign w_new_addr = ADDR_W'({cpu.cpu_din[5:0], r_lbyte});
    assign w_ra_start = (w_setup & ~cpu.cpu_din[6]) | w_data_rd;
    assign w_ra_addr  = w_setup ? w_new_addr : r_addr;
    assign w_edge     = r_sync[1] & ~r_int_prev;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < 8; i++) r_reg[i] <= '0;
            r_addr       <= '0;
            r_rbuf       <= '0;
            r_lbyte      <= '0;
            r_lf         <= 1'b0;
            r_f          <= 1'b0;
            r_sync       <= '0;
            r_int_prev   <= 1'b0;
            r_cpu_dout   <= '0;
            r_vram_addr  <= '0;
            r_vram_wdata <= '0;
            r_vram_we    <= 1'b0;
            r_vram_re    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], frame_int};
            r_int_prev <= r_sync[1];
            r_vram_we  <= 1'b0;
            r_vram_re  <= 1'b0;

            // A status read coinciding with a new edge keeps F set.
            if (w_edge)
                r_f <= 1'b1;
            else if (w_stat_rd)
                r_f <= 1'b0;

            if (w_ctrl_wr) begin
                if (!r_lf) begin
                    r_lbyte     <= cpu.cpu_din;
                    r_addr[7:0] <= cpu.cpu_din;
                    r_lf        <= 1'b1;
                end else begin
                    r_lf <= 1'b0;
                    if (cpu.cpu_din[7])
                        r_reg[cpu.cpu_din[2:0]] <= r_lbyte;
                    else
                        r_addr <= w_new_addr;
                end
            end

            if (w_data_wr) begin
                r_vram_addr  <= r_addr;
                r_vram_wdata <= cpu.cpu_din;
                r_vram_we    <= 1'b1;
                r_rbuf       <= cpu.cpu_din;
                r_addr       <= r_addr + c_one;
                r_lf         <= 1'b0;
            end

            if (w_data_rd) begin
                r_cpu_dout <= r_rbuf;
                r_lf       <= 1'b0;
            end

            if (w_stat_rd) begin
                r_cpu_dout <= {r_f, 7'b0};
                r_lf       <= 1'b0;
            end

            // Read-ahead: issued in the strobe cycle so a read setup fetches
            // from the freshly loaded address.
            case (r_state)
                S_IDLE: begin
                    if (w_ra_start) begin
                        r_vram_addr <= w_ra_addr;
                        r_vram_re   <= 1'b1;
                        r_addr      <= w_ra_addr + c_one;
                        r_state     <= S_PREF;
                    end
                end
                S_PREF: r_state <= S_WAIT;
                S_WAIT: begin
                    r_rbuf  <= vram_rdata;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_mode = 2'd1;
        if (r_reg[1][4])
            w_mode = 2'd0;
        else if (r_reg[1][3])
            w_mode = 2'd2;
        else if (r_reg[0][1])
            w_mode = 2'd3;
    end

    assign cpu.cpu_dout    = r_cpu_dout;
    assign cpu.busy        = w_busy;
    assign vram_addr       = r_vram_addr;
    assign vram_wdata      = r_vram_wdata;
    assign vram_we         = r_vram_we;
    assign vram_re         = r_vram_re;
    assign mode            = w_mode;
    assign name_table_addr = {r_reg[2][3:0], 10'b0};
    assign font_addr       = {r_reg[4][2:0], 11'b0};
    assign video_on        = r_reg[1][6];
    assign text_color      = r_reg[7][7:4];
    assign back_color      = r_reg[7][3:0];
    assign n_int           = ~(r_f & r_reg[1][5]);

    // R3, R5, R6 and spare bits are held but drive nothing.
    assign w_unused = ^{r_reg[0], r_reg[1], r_reg[2], r_reg[3],
                        r_reg[4], r_reg[5], r_reg[6]};

endmodule
`default_nettype wire

// File: tb/tb_vdp_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp_port
// Description : Directed self-checking bench for vdp_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_port;
    logic        clk = 1'b0;
    logic        n_reset;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic        vram_re;
    logic [7:0]  vram_rdata = 8'h00;
    logic        frame_int;
    logic [1:0]  mode;
    logic [13:0] name_table_addr;
    logic [13:0] font_addr;
    logic        video_on;
    logic [3:0]  text_color;
    logic [3:0]  back_color;
    logic        n_int;
    logic [7:0]  vmem [16384];
    int          total = 0;
    int          bad = 0;

    vdp_port_if bus();

    vdp_port #(.ADDR_W(14)) dut (
        .clk             (clk),
        .n_reset         (n_reset),
        .cpu             (bus.slave),
        .vram_addr       (vram_addr),
        .vram_wdata      (vram_wdata),
        .vram_we         (vram_we),
        .vram_re         (vram_re),
        .vram_rdata      (vram_rdata),
        .frame_int       (frame_int),
        .mode            (mode),
        .name_table_addr (name_table_addr),
        .font_addr       (font_addr),
        .video_on        (video_on),
        .text_color      (text_color),
        .back_color      (back_color),
        .n_int           (n_int)
    );

    always #5 clk = ~clk;

    // VRAM model: read data appears the cycle after vram_re is sampled.
    always @(posedge clk) begin
        if (vram_we) vmem[vram_addr] <= vram_wdata;
        if (vram_re) vram_rdata <= vmem[vram_addr];
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic strobe(input logic a0, input logic wr, input logic rd, input logic [7:0] d);
        bus.cpu_a0 = a0; bus.cpu_wr = wr; bus.cpu_rd = rd; bus.cpu_din = d;
        @(posedge clk); #1;
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
    endtask

    task automatic ctrl2(input logic [7:0] b0, input logic [7:0] b1);
        strobe(1'b1, 1'b1, 1'b0, b0);
        idle(4);
        strobe(1'b1, 1'b1, 1'b0, b1);
    endtask

    task automatic test_reset;
        n_reset = 1'b0; frame_int = 1'b0;
        bus.cpu_a0 = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_din = 8'h00;
        idle(3); n_reset = 1'b1; idle(2);
        ctrl2(8'hF4, 8'h87); idle(4);
        strobe(1'b0, 1'b1, 1'b0, 8'h99); idle(4);
        ctrl2(8'h00, 8'h10);
        #2 n_reset = 1'b0; #1;
        total++; if (bus.cpu_dout !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h want 00", bus.cpu_dout); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (vram_addr !== 14'h0 || vram_wdata !== 8'h00) begin bad++; $display("FAIL rst_vram: got addr %h data %h want 0000/00", vram_addr, vram_wdata); end
        total++; if (vram_we !== 1'b0 || vram_re !== 1'b0) begin bad++; $display("FAIL rst_strobes: got we %b re %b want 0/0", vram_we, vram_re); end
        total++; if (mode !== 2'd1 || n_int !== 1'b1 || video_on !== 1'b0) begin bad++; $display("FAIL rst_ctl: got mode %0d n_int %b von %b want 1/1/0", mode, n_int, video_on); end
        total++; if (name_table_addr !== 14'h0 || font_addr !== 14'h0 || text_color !== 4'h0 || back_color !== 4'h0) begin bad++; $display("FAIL rst_regs: got %h %h %h %h want 0", name_table_addr, font_addr, text_color, back_color); end
        idle(2); n_reset = 1'b1; idle(2);
        total++; if (bus.busy !== 1'b0 || vram_re !== 1'b0) begin bad++; $display("FAIL rst_abandon: got busy %b re %b want 0/0", bus.busy, vram_re); end
    endtask

    task automatic test_regs;
        strobe(1'b1, 1'b1, 1'b0, 8'h70); idle(4);
        total++; if (video_on !== 1'b0) begin bad++; $display("FAIL reg_first_byte: got von %b want 0", video_on); end
        strobe(1'b1, 1'b1, 1'b0, 8'h81);
        total++; if (video_on !== 1'b1 || mode !== 2'd0 || n_int !== 1'b1) begin bad++; $display("FAIL reg_r1: got von %b mode %0d n_int %b want 1/0/1", video_on, mode, n_int); end
        idle(4); ctrl2(8'hF4, 8'h87);
        total++; if (text_color !== 4'hF || back_color !== 4'h4) begin bad++; $display("FAIL reg_r7: got %h/%h want f/4", text_color, back_color); end
        idle(4); ctrl2(8'h02, 8'h82);
        total++; if (name_table_addr !== 14'h0800) begin bad++; $display("FAIL reg_r2: got %h want 0800", name_table_addr); end
        idle(4); ctrl2(8'h01, 8'h84);
        total++; if (font_addr !== 14'h0800) begin bad++; $display("FAIL reg_r4: got %h want 0800", font_addr); end
        idle(4); ctrl2(8'hFF, 8'h83); idle(4); ctrl2(8'hFF, 8'h85); idle(4); ctrl2(8'hFF, 8'h86);
        total++; if (name_table_addr !== 14'h0800 || font_addr !== 14'h0800 || text_color !== 4'hF || back_color !== 4'h4 || mode !== 2'd0) begin bad++; $display("FAIL reg_r356: got %h %h %h %h %0d want 0800 0800 f 4 0", name_table_addr, font_addr, text_color, back_color, mode); end
        idle(4); ctrl2(8'h48, 8'h81);
        total++; if (mode !== 2'd2) begin bad++; $display("FAIL mode_m3: got %0d want 2", mode); end
        idle(4); ctrl2(8'h02, 8'h80);
        total++; if (mode !== 2'd2) begin bad++; $display("FAIL mode_prio: got %0d want 2", mode); end
        idle(4); ctrl2(8'h40, 8'h81);
        total++; if (mode !== 2'd3) begin bad++; $display("FAIL mode_r0: got %0d want 3", mode); end
        idle(4); ctrl2(8'h00, 8'h80);
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL mode_default: got %0d want 1", mode); end
        idle(4);
    endtask

    task automatic test_write_wrap;
        ctrl2(8'hFF, 8'h7F); idle(4);
        strobe(1'b0, 1'b1, 1'b0, 8'hAA);
        total++; if (vram_we !== 1'b1 || vram_addr !== 14'h3FFF || vram_wdata !== 8'hAA) begin bad++; $display("FAIL wr_first: got we %b addr %h data %h want 1/3fff/aa", vram_we, vram_addr, vram_wdata); end
        idle(1);
        total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL wr_pulse: got we %b want 0", vram_we); end
        idle(3);
        strobe(1'b0, 1'b1, 1'b1, 8'h55);
        total++; if (vram_we !== 1'b1 || vram_addr !== 14'h0000 || vram_wdata !== 8'h55) begin bad++; $display("FAIL wr_wrap: got we %b addr %h data %h want 1/0000/55", vram_we, vram_addr, vram_wdata); end
        total++; if (vram_re !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_dout !== 8'h00) begin bad++; $display("FAIL wr_rd_same: got re %b busy %b dout %h want 0/0/00", vram_re, bus.busy, bus.cpu_dout); end
        idle(4);
    endtask

    task automatic test_read_ahead;
        vmem[14'h1000] = 8'h12; vmem[14'h1001] = 8'h34; vmem[14'h1002] = 8'h56;
        ctrl2(8'h00, 8'h10);
        total++; if (vram_re !== 1'b1 || vram_addr !== 14'h1000 || bus.busy !== 1'b1) begin bad++; $display("FAIL ra_issue: got re %b addr %h busy %b want 1/1000/1", vram_re, vram_addr, bus.busy); end
        idle(1);
        total++; if (vram_re !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL ra_pref: got re %b busy %b want 0/1", vram_re, bus.busy); end
        idle(1);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ra_done: got busy %b want 0", bus.busy); end
        idle(3);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        total++; if (bus.cpu_dout !== 8'h12 || vram_addr !== 14'h1001 || vram_re !== 1'b1) begin bad++; $display("FAIL ra_rd1: got dout %h addr %h re %b want 12/1001/1", bus.cpu_dout, vram_addr, vram_re); end
        strobe(1'b0, 1'b1, 1'b0, 8'hEE);
        total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL ra_drop_wr: got we %b want 0", vram_we); end
        idle(4);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        total++; if (bus.cpu_dout !== 8'h34 || vram_addr !== 14'h1002) begin bad++; $display("FAIL ra_rd2: got dout %h addr %h want 34/1002", bus.cpu_dout, vram_addr); end
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        total++; if (bus.cpu_dout !== 8'h34) begin bad++; $display("FAIL ra_drop_rd: got dout %h want 34", bus.cpu_dout); end
        idle(4);
    endtask

    task automatic test_interrupt;
        logic seen;
        ctrl2(8'h60, 8'h81); idle(4);
        total++; if (n_int !== 1'b1) begin bad++; $display("FAIL irq_idle: got n_int %b want 1", n_int); end
        frame_int = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (n_int === 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL irq_assert: got n_int %b want 0 within 3 clk", n_int); end
        frame_int = 1'b0; idle(2);
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        total++; if (bus.cpu_dout !== 8'h80 || n_int !== 1'b1) begin bad++; $display("FAIL irq_status: got dout %h n_int %b want 80/1", bus.cpu_dout, n_int); end
        idle(4);
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        total++; if (bus.cpu_dout !== 8'h00) begin bad++; $display("FAIL irq_status2: got dout %h want 00", bus.cpu_dout); end
        idle(4);
        // Edge lands on the same clock as a status read: flag stays set.
        frame_int = 1'b1; idle(2);
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        total++; if (bus.cpu_dout !== 8'h00 || n_int !== 1'b0) begin bad++; $display("FAIL irq_set_wins: got dout %h n_int %b want 00/0", bus.cpu_dout, n_int); end
        idle(4);
        strobe(1'b1, 1'b0, 1'b1, 8'h00);
        total++; if (bus.cpu_dout !== 8'h80 || n_int !== 1'b1) begin bad++; $display("FAIL irq_after_set: got dout %h n_int %b want 80/1", bus.cpu_dout, n_int); end
        frame_int = 1'b0; idle(4);
    endtask

    task automatic test_latch_clear;
        ctrl2(8'h00, 8'h81); idle(4);
        total++; if (video_on !== 1'b0) begin bad++; $display("FAIL lc_pre: got von %b want 0", video_on); end
        strobe(1'b1, 1'b1, 1'b0, 8'h05); idle(4);
        strobe(1'b1, 1'b0, 1'b1, 8'h00); idle(4);
        ctrl2(8'h40, 8'h81);
        total++; if (video_on !== 1'b1 || mode !== 2'd1 || n_int !== 1'b1) begin bad++; $display("FAIL lc_r1: got von %b mode %0d n_int %b want 1/1/1", video_on, mode, n_int); end
        idle(4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;
        test_reset();
        test_regs();
        test_write_wrap();
        test_read_ahead();
        test_interrupt();
        test_latch_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vdp_port.md
# vdp_port

CPU-side port interface of the MSX VDP (TMS9918-style I/O ports 0x98/0x99), running on the CPU clock. It decodes data-port and control-port accesses into:
- VRAM write/read-ahead cycles on the CPU-side port of the video RAM;
- the VDP register file that drives the `video` block's mode, table-base, blanking and colour inputs;
- the frame status flag that produces `n_int` to the Z80.

It is the writer/initiator end of the interface the video block consumes.

## Interface
Parameters:
- ADDR_W, 14, VRAM address width.

Ports:
- clk  in  1  CPU clock; all logic on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- cpu_a0  in  1  port select: 0 = data port (0x98), 1 = control/status port (0x99).
- cpu_wr  in  1  one-cycle write strobe.
- cpu_rd  in  1  one-cycle read strobe.
- cpu_din  in  8  write data.
- cpu_dout  out  8  registered read data.
- busy  out  1  read-ahead in progress.
- vram_addr  out  14  VRAM address (to video vga_addr).
- vram_wdata  out  8  VRAM write data (to video vga_din).
- vram_we  out  1  one-cycle VRAM write (to video vga_wr).
- vram_re  out  1  one-cycle VRAM read (to video vga_rd).
- vram_rdata  in  8  VRAM read data, valid the cycle after the edge that samples vram_re.
- frame_int  in  1  frame interrupt level from video clock domain (active high, ≥1 CPU clk wide).
- mode  out  2  display mode.
- name_table_addr  out  14  {R2[3:0], 10'b0}.
- font_addr  out  14  {R4[2:0], 11'b0}.
- video_on  out  1  R1[6].
- text_color  out  4  R7[7:4].
- back_color  out  4  R7[3:0].
- n_int  out  1  active-low interrupt = !(F & R1[5]).

## Operation
State:
- Registers R0–R7 (8 bits each).
- Address pointer `addr` (14 bits).
- Read buffer `rbuf` (8 bits).
- First-byte latch `lbyte`.
- Latch flag `lf`.
- Status flag `F`.
- Read-ahead FSM: IDLE → PREF → WAIT → IDLE.

Mode decode, first match wins:
- R1[4]=1 → 0 (text 40 col)
- R1[3]=1 → 2
- R0[1]=1 → 3
- else → 1

Control write (a0=1, wr):
- lf=0: lbyte ← din; addr[7:0] ← din; lf ← 1.
- lf=1, din[7]=1: R[din[2:0]] ← lbyte; lf ← 0.
- lf=1, din[7]=0: addr ← {din[5:0], lbyte}; lf ← 0. If din[6]=0 (read setup), start a read-ahead at the new addr.

Data write (a0=0, wr):
- vram_addr ← addr; vram_wdata ← din; vram_we ← 1; rbuf ← din; addr ← addr+1; lf ← 0.

Data read (a0=0, rd):
- cpu_dout ← rbuf; lf ← 0; start a read-ahead at addr.

Status read (a0=1, rd):
- cpu_dout ← {F, 7'b0}; F ← 0; lf ← 0.

Read-ahead:
- IDLE: on start, vram_addr ← addr, vram_re ← 1, addr ← addr+1 → PREF.
- PREF: vram_re ← 0 → WAIT.
- WAIT: rbuf ← vram_rdata → IDLE.
- busy = (state ≠ IDLE).

Interrupt path:
- frame_int goes through a 2-FF synchronizer, then rising-edge detect; the detected edge sets F.
- F and R1[5] drive n_int.

Boundary rules:
- addr arithmetic is modulo 2^14; 0x3FFF+1 → 0x0000.
- wr and rd in the same cycle: wr executes, rd ignored.
- Any strobe while busy=1 is dropped: no state change and cpu_dout unchanged. The CPU contract spaces accesses ≥4 clk apart.
- Edge-set and status-clear of F in the same cycle: set wins, and the read returns the old F.
- Writes to R3, R5, R6 are stored with no output effect.
- n_reset asserted mid-operation: everything returns to reset values immediately and any read-ahead is abandoned.

## Timing
Reset values:
- cpu_dout=0, busy=0, vram_addr=0, vram_wdata=0, vram_we=0, vram_re=0.
- R0–R7=0, so mode=1, name_table_addr=0, font_addr=0, video_on=0, text_color=0, back_color=0.
- n_int=1; F, lf, addr, rbuf all 0.

Latencies (E0 = edge sampling the strobe):
- cpu_dout is valid after E0 and holds until the next accepted read.
- vram_we/vram_re pulse high for exactly the cycle after E0.
- Register outputs update after E0 of the second control byte.
- rbuf is loaded at E2; busy is high E0→E2.
- frame_int rise → n_int low after ≤3 edges, with IE=1.
- Status read → n_int high after E0.

## Test plan
1. **Reset:** pulse n_reset low mid-frame → all outputs at the listed reset values; mode=1, n_int=1.
2. **Register writes:**
   - ctrl 0x70, 0x81 → video_on=1, mode=0, IE=1.
   - ctrl 0xF4, 0x87 → text_color=15, back_color=4.
   - ctrl 0x02, 0x82 → name_table_addr=0x0800.
   - ctrl 0x01, 0x84 → font_addr=0x0800.
3. **Write wrap:** ctrl 0xFF, 0x7F; data wr 0xAA then 0x55 → vram_we at 0x3FFF with data 0xAA, then at 0x0000 with data 0x55.
4. **Read-ahead:** VRAM 0x1000=0x12, 0x1001=0x34; ctrl 0x00, 0x10 → vram_re at 0x1000, busy for 2 clk. Data rd → 0x12; next data rd → 0x34. A strobe while busy is dropped.
5. **Interrupt:** IE=1; frame_int rises → n_int=0 within 3 clk. Status rd → cpu_dout=0x80 and n_int=1. Second status rd → 0x00.
6. **Latch clear:** ctrl 0x05, status rd, ctrl 0x40, 0x81 → R1=0x40 (video_on=1). 0x05 was discarded, and R5 is unchanged.
